// File: rtl/ingress_arb_pkg.sv
// ingress_arb_pkg: descriptor field positions and FSM encoding shared by the ingress arbiter.
// Rev 1.0
`default_nettype none

package ingress_arb_pkg;

  localparam int ERR_BIT = 15;
  localparam int SRC_MSB = 14;
  localparam int SRC_LSB = 11;
  localparam int LEN_MSB = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PTR_RD  = 3'd1,
    S_PTR_LAT = 3'd2,
    S_CHECK   = 3'd3,
    S_XFER    = 3'd4,
    S_DESC    = 3'd5,
    S_DROP    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ingress_frame_arbiter_rr.sv
// rr_arbiter_4: combinational round-robin pick of the first requester at or after ptr.
// Rev 1.0
`default_nettype none

module rr_arbiter_4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_valid_o
);

  logic [1:0] w_idx;

  // Scan farthest-first so the requester closest to ptr overwrites the others.
  always_comb begin
    gnt_idx_o   = 2'd0;
    gnt_valid_o = 1'b0;
    w_idx       = ptr_i;
    for (int k = 3; k >= 0; k--) begin
      w_idx = ptr_i + 2'(k);
      if (req_i[w_idx]) begin
        gnt_idx_o   = w_idx;
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ingress_frame_arbiter.sv
// ingress_frame_arbiter: round-robin frame mover from 4 MAC queues into the shared sfifo/ptr_sfifo.
// Rev 1.0
`default_nettype none

module ingress_frame_arbiter
  import ingress_arb_pkg::*;
#(
  parameter int NPORT        = 4,
  parameter int DATA_DEPTH   = 4096,
  parameter int CNT_W        = 12,
  parameter int LEN_W        = 11,
  parameter int SPACE_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORT-1:0]     in_ptr_empty,
  output logic [NPORT-1:0]     in_ptr_rd,
  input  logic [16*NPORT-1:0]  in_ptr_dout,
  output logic [NPORT-1:0]     in_data_rd,
  input  logic [8*NPORT-1:0]   in_data_dout,
  output logic [7:0]           sfifo_din,
  output logic                 sfifo_wr,
  input  logic [CNT_W-1:0]     sfifo_cnt,
  output logic [15:0]          ptr_sfifo_din,
  output logic                 ptr_sfifo_wr,
  input  logic                 ptr_sfifo_full,
  output logic                 busy,
  output logic [1:0]           grant_port,
  output logic [15:0]          drop_cnt
);

  localparam logic [CNT_W:0]   SPACE_LIMIT = (CNT_W+1)'(DATA_DEPTH - SPACE_MARGIN);
  localparam logic [LEN_W-1:0] LEN_ZERO    = '0;
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);

  state_t            state_q;
  logic [1:0]        rr_q;
  logic [1:0]        grant_q;
  logic [LEN_W-1:0]  len_q;
  logic              err_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [NPORT-1:0]  in_ptr_rd_q;
  logic [NPORT-1:0]  in_data_rd_q;
  logic              sfifo_wr_q;
  logic              ptr_wr_q;
  logic [15:0]       ptr_din_q;
  logic              busy_q;
  logic [15:0]       drop_q;

  logic [NPORT-1:0]  w_req;
  logic [1:0]        w_gnt_idx;
  logic              w_gnt_valid;
  logic [15:0]       w_ptr_word;
  logic [7:0]        w_data_byte;
  logic [CNT_W:0]    w_space_sum;
  logic              w_space_ok;
  logic              w_unused_src;

  assign w_req        = ~in_ptr_empty;
  assign w_ptr_word   = in_ptr_dout[16*grant_q +: 16];
  assign w_data_byte  = in_data_dout[8*grant_q +: 8];
  assign w_unused_src = ^w_ptr_word[SRC_MSB:SRC_LSB];

  // One extra bit so occupancy + len can never wrap before the compare.
  assign w_space_sum  = {1'b0, sfifo_cnt} + {{(CNT_W+1-LEN_W){1'b0}}, len_q};
  assign w_space_ok   = !ptr_sfifo_full && (w_space_sum <= SPACE_LIMIT);

  rr_arbiter_4 u_rr (
    .req_i       (w_req),
    .ptr_i       (rr_q),
    .gnt_idx_o   (w_gnt_idx),
    .gnt_valid_o (w_gnt_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= 2'd0;
      grant_q      <= 2'd0;
      len_q        <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      in_ptr_rd_q  <= '0;
      in_data_rd_q <= '0;
      sfifo_wr_q   <= 1'b0;
      ptr_wr_q     <= 1'b0;
      ptr_din_q    <= 16'h0000;
      busy_q       <= 1'b0;
      drop_q       <= 16'h0000;
    end else begin
      in_ptr_rd_q <= '0;
      sfifo_wr_q  <= (state_q == S_XFER);
      case (state_q)
        S_IDLE: begin
          if (w_gnt_valid) begin
            grant_q     <= w_gnt_idx;
            in_ptr_rd_q <= onehot4(w_gnt_idx);
            busy_q      <= 1'b1;
            state_q     <= S_PTR_RD;
          end
        end
        S_PTR_RD: state_q <= S_PTR_LAT;
        S_PTR_LAT: begin
          len_q   <= w_ptr_word[LEN_MSB:0];
          err_q   <= w_ptr_word[ERR_BIT];
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (err_q || (len_q == LEN_ZERO)) begin
            cnt_q        <= len_q;
            in_data_rd_q <= (len_q == LEN_ZERO) ? '0 : onehot4(grant_q);
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            state_q      <= S_DROP;
          end else if (w_space_ok) begin
            cnt_q        <= len_q;
            in_data_rd_q <= onehot4(grant_q);
            state_q      <= S_XFER;
          end
        end
        S_XFER: begin
          if (cnt_q <= LEN_ONE) begin
            in_data_rd_q <= '0;
            state_q      <= S_DESC;
          end else begin
            cnt_q <= cnt_q - LEN_ONE;
          end
        end
        // First DESC cycle carries the last delayed byte; the second carries the descriptor.
        S_DESC: begin
          if (!ptr_wr_q) begin
            ptr_wr_q  <= 1'b1;
            ptr_din_q <= {1'b0, onehot4(grant_q), len_q};
          end else begin
            ptr_wr_q <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_DROP: begin
          if (cnt_q <= LEN_ONE) begin
            in_data_rd_q <= '0;
            state_q      <= S_DONE;
          end else begin
            cnt_q <= cnt_q - LEN_ONE;
          end
        end
        S_DONE: begin
          rr_q    <= grant_q + 2'd1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ptr_rd     = in_ptr_rd_q;
  assign in_data_rd    = in_data_rd_q;
  assign sfifo_wr      = sfifo_wr_q;
  // The byte sits in the port FIFO's output register, so this mux adds no extra stage.
  assign sfifo_din     = sfifo_wr_q ? w_data_byte : 8'h00;
  assign ptr_sfifo_wr  = ptr_wr_q;
  assign ptr_sfifo_din = ptr_din_q;
  assign busy          = busy_q;
  assign grant_port    = grant_q;
  assign drop_cnt      = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_ingress_frame_arbiter.sv
// tb_ingress_frame_arbiter: directed self-checking bench for the ingress frame arbiter.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_ingress_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_ptr_empty = 4'hF;
  logic [3:0]  in_ptr_rd;
  logic [63:0] in_ptr_dout;
  logic [3:0]  in_data_rd;
  logic [31:0] in_data_dout;
  logic [7:0]  sfifo_din;
  logic        sfifo_wr;
  logic [11:0] sfifo_cnt;
  logic [15:0] ptr_sfifo_din;
  logic        ptr_sfifo_wr;
  logic        ptr_sfifo_full;
  logic        busy;
  logic [1:0]  grant_port;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  ingress_frame_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .in_ptr_empty   (in_ptr_empty),
    .in_ptr_rd      (in_ptr_rd),
    .in_ptr_dout    (in_ptr_dout),
    .in_data_rd     (in_data_rd),
    .in_data_dout   (in_data_dout),
    .sfifo_din      (sfifo_din),
    .sfifo_wr       (sfifo_wr),
    .sfifo_cnt      (sfifo_cnt),
    .ptr_sfifo_din  (ptr_sfifo_din),
    .ptr_sfifo_wr   (ptr_sfifo_wr),
    .ptr_sfifo_full (ptr_sfifo_full),
    .busy           (busy),
    .grant_port     (grant_port),
    .drop_cnt       (drop_cnt)
  );

  // Per-port queue model: the initial block owns the write pointers, the clocked block the read side.
  logic [15:0] pmem [4][64];
  logic [7:0]  dmem [4][8192];
  int          pwp [4] = '{0, 0, 0, 0};
  int          dwp [4] = '{0, 0, 0, 0};
  int          prp [4] = '{0, 0, 0, 0};
  int          drp [4] = '{0, 0, 0, 0};
  logic [15:0] pdout [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic [7:0]  ddout [4] = '{8'h0, 8'h0, 8'h0, 8'h0};

  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (in_ptr_rd[p]) begin
        pdout[p] <= pmem[p][prp[p]];
        prp[p]   <= prp[p] + 1;
      end
      if (in_data_rd[p]) begin
        ddout[p] <= dmem[p][drp[p]];
        drp[p]   <= drp[p] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) in_ptr_empty[p] <= (prp[p] == pwp[p]);
  end

  assign in_ptr_dout  = {pdout[3], pdout[2], pdout[1], pdout[0]};
  assign in_data_dout = {ddout[3], ddout[2], ddout[1], ddout[0]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  oq[$];
  int          wcyc[$];
  logic [15:0] descq[$];
  int          dcyc[$];
  int          rdport[$];
  int          rdcyc[$];
  int          drdcyc[$];
  int          bfall[$];
  logic        busy_d = 1'b0;

  always @(negedge clk) begin
    if (sfifo_wr) begin
      oq.push_back(sfifo_din);
      wcyc.push_back(cyc);
    end
    if (ptr_sfifo_wr) begin
      descq.push_back(ptr_sfifo_din);
      dcyc.push_back(cyc);
    end
    for (int p = 0; p < 4; p++) if (in_ptr_rd[p]) begin
      rdport.push_back(p);
      rdcyc.push_back(cyc);
    end
    if (in_data_rd != 4'h0) drdcyc.push_back(cyc);
    if (busy_d && !busy) bfall.push_back(cyc);
    busy_d <= busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int p, input logic [15:0] desc, input int n, input logic [7:0] base);
    pmem[p][pwp[p]] = desc;
    pwp[p] = pwp[p] + 1;
    for (int i = 0; i < n; i++) begin
      dmem[p][dwp[p]] = base + 8'(i);
      dwp[p] = dwp[p] + 1;
    end
  endtask

  task automatic wait_quiet(input int budget, output bit timed_out);
    int stable;
    stable = 0;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && in_ptr_empty == 4'hF) stable++; else stable = 0;
      if (stable >= 4) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sfifo_cnt = 12'd0;
    ptr_sfifo_full = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, sfifo_wr, ptr_sfifo_wr, in_ptr_rd, in_data_rd, grant_port} !== 13'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h expected 0", {busy, sfifo_wr, ptr_sfifo_wr, in_ptr_rd, in_data_rd, grant_port});
    end
    checks++;
    if ({sfifo_din, ptr_sfifo_din, drop_cnt} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {sfifo_din, ptr_sfifo_din, drop_cnt});
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || in_ptr_rd !== 4'h0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b ptr_rd=%h expected 0/0", busy, in_ptr_rd);
    end
  endtask

  task automatic test_all_ports();
    int b_o, b_d, b_r, bad;
    bit to;
    logic [15:0] exp_desc [4] = '{16'h083F, 16'h103F, 16'h203F, 16'h403F};
    b_o = oq.size(); b_d = descq.size(); b_r = rdport.size();
    for (int p = 0; p < 4; p++) push_frame(p, 16'h003F, 63, 8'(p * 64));
    wait_quiet(1000, to);
    checks++;
    if (to) begin errors++; $display("FAIL all_ports_timeout: busy=%b empty=%h", busy, in_ptr_empty); end
    checks++;
    if (descq.size() != b_d + 4 || rdport.size() != b_r + 4) begin
      errors++;
      $display("FAIL all_ports_count: desc=%0d rd=%0d expected 4/4", descq.size() - b_d, rdport.size() - b_r);
    end else begin
      bad = 0;
      for (int i = 0; i < 4; i++) if (descq[b_d+i] !== exp_desc[i] || rdport[b_r+i] != i) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL all_ports_order: first desc=%h port=%0d, %0d entries wrong, expected 083F.. ports 0..3", descq[b_d], rdport[b_r], bad);
      end
    end
    checks++;
    bad = 0;
    if (oq.size() != b_o + 252) bad = -1;
    else for (int k = 0; k < 252; k++) if (oq[b_o+k] !== 8'((k / 63) * 64 + (k % 63))) bad++;
    if (bad != 0) begin
      errors++;
      $display("FAIL all_ports_data: bytes=%0d bad=%0d expected 252 bytes in port order", oq.size() - b_o, bad);
    end
  endtask

  task automatic test_single_port2();
    int b_o, b_w, b_d, b_r, b_f, k, bad;
    bit to;
    b_o = oq.size(); b_w = wcyc.size(); b_d = descq.size(); b_r = rdcyc.size(); b_f = bfall.size();
    k = cyc;
    push_frame(2, 16'h003E, 62, 8'h01);
    wait_quiet(500, to);
    checks++;
    if (to || rdcyc.size() != b_r + 1 || descq.size() != b_d + 1 || bfall.size() != b_f + 1 || wcyc.size() != b_w + 62) begin
      errors++;
      $display("FAIL p2_counts: to=%b rd=%0d desc=%0d wr=%0d expected 0/1/1/62", to, rdcyc.size() - b_r, descq.size() - b_d, wcyc.size() - b_w);
    end else begin
      checks++;
      if (rdcyc[b_r] != k + 1 || rdport[b_r] != 2) begin
        errors++; $display("FAIL p2_ptr_rd: cycle=%0d port=%0d expected %0d/2", rdcyc[b_r] - k, rdport[b_r], 1);
      end
      checks++;
      if (wcyc[b_w] != k + 5 || wcyc[b_w+61] != k + 66) begin
        errors++; $display("FAIL p2_wr_window: first=%0d last=%0d expected 5/66", wcyc[b_w] - k, wcyc[b_w+61] - k);
      end
      checks++;
      if (descq[b_d] !== 16'h203E || dcyc[b_d] != k + 67) begin
        errors++; $display("FAIL p2_desc: value=%h cycle=%0d expected 203E/67", descq[b_d], dcyc[b_d] - k);
      end
      checks++;
      if (bfall[b_f] != k + 69) begin
        errors++; $display("FAIL p2_idle: cycle=%0d expected 69", bfall[b_f] - k);
      end
      bad = 0;
      for (int i = 0; i < 62; i++) if (oq[b_o+i] !== 8'(i + 1)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL p2_data: %0d bytes wrong, first=%h expected 01..3E", bad, oq[b_o]); end
    end
    checks++;
    if (drop_cnt !== 16'd0) begin errors++; $display("FAIL p2_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_error_drop();
    int b_o, b_d, b_n, bad;
    bit to;
    b_o = oq.size(); b_d = descq.size(); b_n = drdcyc.size();
    push_frame(0, 16'h8040, 64, 8'hA0);
    push_frame(0, 16'h0010, 16, 8'h30);
    wait_quiet(800, to);
    checks++;
    if (to) begin errors++; $display("FAIL drop_timeout: busy=%b", busy); end
    checks++;
    if (drdcyc.size() - b_n != 80) begin
      errors++; $display("FAIL drop_reads: got %0d expected 80", drdcyc.size() - b_n);
    end
    checks++;
    if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_cnt: got %0d expected 1", drop_cnt); end
    checks++;
    if (descq.size() != b_d + 1) begin
      errors++; $display("FAIL drop_desc_count: got %0d expected 1", descq.size() - b_d);
    end else if (descq[b_d] !== 16'h0810) begin
      errors++; $display("FAIL drop_desc: got %h expected 0810", descq[b_d]);
    end
    checks++;
    bad = 0;
    if (oq.size() != b_o + 16) bad = -1;
    else for (int i = 0; i < 16; i++) if (oq[b_o+i] !== 8'(8'h30 + i)) bad++;
    if (bad != 0) begin errors++; $display("FAIL drop_good_data: bytes=%0d bad=%0d expected 16 bytes 30..3F", oq.size() - b_o, bad); end
  endtask

  task automatic test_fairness();
    int b_o, b_d, b_r, bad;
    bit to;
    int          exp_port [3] = '{1, 3, 1};
    logic [15:0] exp_desc [3] = '{16'h1005, 16'h4005, 16'h1005};
    logic [7:0]  exp_base [3] = '{8'h10, 8'h40, 8'h20};
    b_o = oq.size(); b_d = descq.size(); b_r = rdport.size();
    push_frame(1, 16'h0005, 5, 8'h10);
    push_frame(1, 16'h0005, 5, 8'h20);
    push_frame(3, 16'h0005, 5, 8'h40);
    wait_quiet(500, to);
    checks++;
    if (to || rdport.size() != b_r + 3 || descq.size() != b_d + 3 || oq.size() != b_o + 15) begin
      errors++;
      $display("FAIL rr_counts: to=%b rd=%0d desc=%0d bytes=%0d expected 0/3/3/15", to, rdport.size() - b_r, descq.size() - b_d, oq.size() - b_o);
    end else begin
      bad = 0;
      for (int i = 0; i < 3; i++) if (rdport[b_r+i] != exp_port[i] || descq[b_d+i] !== exp_desc[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rr_order: ports %0d,%0d,%0d expected 1,3,1", rdport[b_r], rdport[b_r+1], rdport[b_r+2]);
      end
      bad = 0;
      for (int i = 0; i < 15; i++) if (oq[b_o+i] !== 8'(exp_base[i/5] + 8'(i % 5))) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rr_data: %0d bytes wrong", bad); end
    end
  endtask

  task automatic test_backpressure();
    int b_o, b_d, b_n, k, bad;
    bit to;
    b_o = oq.size(); b_d = descq.size(); b_n = drdcyc.size();
    sfifo_cnt = 12'd3000;
    push_frame(2, 16'h05EA, 1514, 8'h00);
    repeat (20) tick();
    checks++;
    if (busy !== 1'b1 || drdcyc.size() != b_n) begin
      errors++; $display("FAIL bp_hold: busy=%b reads=%0d expected 1/0", busy, drdcyc.size() - b_n);
    end
    sfifo_cnt = 12'd2579;
    repeat (5) tick();
    checks++;
    if (drdcyc.size() != b_n) begin errors++; $display("FAIL bp_one_over: reads=%0d expected 0", drdcyc.size() - b_n); end
    sfifo_cnt = 12'd2578;
    ptr_sfifo_full = 1'b1;
    repeat (5) tick();
    checks++;
    if (drdcyc.size() != b_n) begin errors++; $display("FAIL bp_ptr_full: reads=%0d expected 0", drdcyc.size() - b_n); end
    k = cyc;
    ptr_sfifo_full = 1'b0;
    wait_quiet(3000, to);
    sfifo_cnt = 12'd0;
    checks++;
    if (to || drdcyc.size() != b_n + 1514) begin
      errors++; $display("FAIL bp_reads: to=%b reads=%0d expected 0/1514", to, drdcyc.size() - b_n);
    end else if (drdcyc[b_n] != k + 1) begin
      errors++; $display("FAIL bp_start: first read at +%0d expected +1", drdcyc[b_n] - k);
    end
    checks++;
    if (descq.size() != b_d + 1) begin
      errors++; $display("FAIL bp_desc_count: got %0d expected 1", descq.size() - b_d);
    end else if (descq[b_d] !== 16'h25EA) begin
      errors++; $display("FAIL bp_desc: got %h expected 25EA", descq[b_d]);
    end
    checks++;
    bad = 0;
    if (oq.size() != b_o + 1514) bad = -1;
    else for (int i = 0; i < 1514; i++) if (oq[b_o+i] !== 8'(i)) bad++;
    if (bad != 0) begin errors++; $display("FAIL bp_data: bytes=%0d bad=%0d expected 1514", oq.size() - b_o, bad); end
  endtask

  task automatic test_reset_midframe();
    int b_o, b_d, b_r, bad;
    bit to;
    b_o = oq.size();
    push_frame(2, 16'h05EA, 1514, 8'h55);
    for (int i = 0; i < 3000 && oq.size() < b_o + 700; i++) tick();
    checks++;
    if (oq.size() < b_o + 700) begin errors++; $display("FAIL mid_timeout: bytes=%0d expected >=700", oq.size() - b_o); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, sfifo_wr, ptr_sfifo_wr, in_ptr_rd, in_data_rd, grant_port} !== 13'h0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got %h expected 0", {busy, sfifo_wr, ptr_sfifo_wr, in_ptr_rd, in_data_rd, grant_port});
    end
    checks++;
    if ({sfifo_din, ptr_sfifo_din, drop_cnt} !== 40'h0) begin
      errors++; $display("FAIL mid_reset_data: got %h expected 0", {sfifo_din, ptr_sfifo_din, drop_cnt});
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick();
    b_o = oq.size(); b_d = descq.size(); b_r = rdport.size();
    push_frame(1, 16'h0004, 4, 8'h70);
    push_frame(3, 16'h0004, 4, 8'h78);
    wait_quiet(500, to);
    checks++;
    if (to || rdport.size() != b_r + 2 || descq.size() != b_d + 2 || oq.size() != b_o + 8) begin
      errors++;
      $display("FAIL post_reset_counts: to=%b rd=%0d desc=%0d bytes=%0d expected 0/2/2/8", to, rdport.size() - b_r, descq.size() - b_d, oq.size() - b_o);
    end else begin
      checks++;
      if (rdport[b_r] != 1 || rdport[b_r+1] != 3 || descq[b_d] !== 16'h1004 || descq[b_d+1] !== 16'h4004) begin
        errors++;
        $display("FAIL post_reset_order: ports %0d,%0d desc %h,%h expected 1,3 1004,4004", rdport[b_r], rdport[b_r+1], descq[b_d], descq[b_d+1]);
      end
      bad = 0;
      for (int i = 0; i < 8; i++) if (oq[b_o+i] !== 8'((i < 4) ? 8'h70 + i : 8'h78 + i - 4)) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL post_reset_data: %0d bytes wrong", bad); end
    end
  endtask

  initial begin
    test_reset();
    test_all_ports();
    test_single_port2();
    test_error_drop();
    test_fairness();
    test_backpressure();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
